autenticacao_sequencial: RTL

- Clocked, parametrised authentication controller. Successor to the fixed 3-input/7-permission combinational authenticator.
- Holds a programmable table of user PINs and permission vectors. Checks a submitted user ID + PIN and drives a registered permission vector for a timed grant window.
- Counts consecutive failures and enters a timed lockout. Sits between the keypad/input front end and the access actuators.

---
 rtl/autenticacao_sequencial_if.sv | 36 +++
 rtl/autenticacao_sequencial.sv | 135 +++++++++++++
 2 files changed

// File: rtl/autenticacao_sequencial_if.sv
// Interface bundle for the sequential authentication controller.
// Groups everything except clk/rst:
//   request side : req, user_id, pin
//   program side : prog_en, prog_id, prog_pin, prog_perm
//   status side  : busy, granted, denied, locked, perm_out, fail_cnt
// master = front end / keypad driver, slave = the controller.
interface autenticacao_sequencial_if #(
  parameter int ID_W   = 2,
  parameter int PIN_W  = 4,
  parameter int N_PERM = 7,
  parameter int FAIL_W = 2
);
  logic              req;
  logic [ID_W-1:0]   user_id;
  logic [PIN_W-1:0]  pin;
  logic              prog_en;
  logic [ID_W-1:0]   prog_id;
  logic [PIN_W-1:0]  prog_pin;
  logic [N_PERM-1:0] prog_perm;
  logic              busy;
  logic              granted;
  logic              denied;
  logic              locked;
  logic [N_PERM-1:0] perm_out;
  logic [FAIL_W-1:0] fail_cnt;

  modport master (
    output req, user_id, pin, prog_en, prog_id, prog_pin, prog_perm,
    input  busy, granted, denied, locked, perm_out, fail_cnt
  );

  modport slave (
    input  req, user_id, pin, prog_en, prog_id, prog_pin, prog_perm,
    output busy, granted, denied, locked, perm_out, fail_cnt
  );
endinterface

// File: rtl/autenticacao_sequencial.sv
// Sequential authentication controller.
// Holds a programmable table of {PIN, permission} per user ID. A request
// captured in IDLE is checked one cycle later; a match drives the stored
// permission vector for GRANT_CYCLES cycles, a mismatch pulses denied and
// bumps the consecutive-failure count. MAX_TRIES failures in a row put the
// block into LOCK for LOCK_CYCLES cycles.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - autenticacao_sequencial_if.slave (request, program, status)
// Optional build macro AUTH_MASTER_EN: adds MASTER_PIN, which matches any
// user ID in CHECK and grants all-ones permissions.
// All outputs come from flops (state / perm / fail registers); there is no
// combinational path from the inputs to any output.
module autenticacao_sequencial #(
  parameter int ID_W         = 2,
  parameter int PIN_W        = 4,
  parameter int N_PERM       = 7,
  parameter int MAX_TRIES    = 3,
  parameter int GRANT_CYCLES = 4,
  parameter int LOCK_CYCLES  = 8
`ifdef AUTH_MASTER_EN
  , parameter logic [PIN_W-1:0] MASTER_PIN = '1
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  autenticacao_sequencial_if.slave  bus
);

  localparam int DEPTH  = 1 << ID_W;
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int TMAX   = (GRANT_CYCLES > LOCK_CYCLES) ? GRANT_CYCLES : LOCK_CYCLES;
  localparam int TMR_W  = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {IDLE, CHECK, GRANT, DENY, LOCK} state_t;

  state_t state, next_state;

  logic [DEPTH-1:0][PIN_W-1:0]  tbl_pin;
  logic [DEPTH-1:0][N_PERM-1:0] tbl_perm;
  logic [ID_W-1:0]              cap_id;
  logic [PIN_W-1:0]             cap_pin;
  logic [FAIL_W-1:0]            fail_cnt;
  logic [N_PERM-1:0]            perm_q;
  logic [TMR_W-1:0]             tmr;

  logic              match;
  logic [N_PERM-1:0] match_perm;
  logic              grant_done;
  logic              lock_done;
  logic              at_max;

  // Table lookup on the captured request
  always_comb begin
    match      = (cap_pin == tbl_pin[cap_id]);
    match_perm = tbl_perm[cap_id];
`ifdef AUTH_MASTER_EN
    if (cap_pin == MASTER_PIN) begin
      match      = 1'b1;
      match_perm = '1;
    end
`endif
  end

  // tmr restarts on every state change, so it counts cycles spent in the
  // current GRANT or LOCK window.
  assign grant_done = (tmr == TMR_W'(GRANT_CYCLES - 1));
  assign lock_done  = (tmr == TMR_W'(LOCK_CYCLES - 1));
  assign at_max     = (fail_cnt == FAIL_W'(MAX_TRIES));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (bus.req && !bus.prog_en) next_state = CHECK;
      CHECK: next_state = match ? GRANT : DENY;
      GRANT: if (grant_done) next_state = IDLE;
      DENY:  next_state = at_max ? LOCK : IDLE;
      LOCK:  if (lock_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_pin  <= '0;
      tbl_perm <= '0;
      cap_id   <= '0;
      cap_pin  <= '0;
      fail_cnt <= '0;
      perm_q   <= '0;
      tmr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A write in the same cycle as req wins; req is dropped.
          if (bus.prog_en) begin
            tbl_pin[bus.prog_id]  <= bus.prog_pin;
            tbl_perm[bus.prog_id] <= bus.prog_perm;
          end else if (bus.req) begin
            cap_id  <= bus.user_id;
            cap_pin <= bus.pin;
          end
        end
        CHECK: begin
          if (match)        fail_cnt <= '0;
          else if (!at_max) fail_cnt <= fail_cnt + 1'b1;
        end
        LOCK: if (lock_done) fail_cnt <= '0;
        default: ;
      endcase

      // Permissions are latched on GRANT entry so table writes cannot
      // disturb an open window; cleared whenever GRANT is not next.
      if (next_state == GRANT) perm_q <= (state == CHECK) ? match_perm : perm_q;
      else                     perm_q <= '0;

      if (next_state != state)                 tmr <= '0;
      else if (state == GRANT || state == LOCK) tmr <= tmr + 1'b1;
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.granted  = (state == GRANT);
  assign bus.denied   = (state == DENY);
  assign bus.locked   = (state == LOCK);
  assign bus.perm_out = perm_q;
  assign bus.fail_cnt = fail_cnt;

endmodule
